spi_master_tx: RTL and testbench
================================

// Module: spi_master_tx
// PURPOSE
//   SPI mode-0 master (CPOL=0, CPHA=0), MSB first: drives sclk/cs/mosi toward the board's
//   SPI slave receiver and samples miso. Generates SCLK by dividing the system clock.
//   Used as loopback stimulus for the slave on-chip and as the host-side link to peripherals.
// PARAMETERS
//   CLK_DIV  25  clk cycles per SCLK half-period (>=2); 25 @ 50 MHz -> 1 MHz SCLK
//   DATA_W   8   bits per transfer
//   CS_GAP   4   clk cycles cs held high between non-burst transfers (>=1)
// PORTS
//   clk       in   1       system clock; single clock domain
//   rst       in   1       synchronous reset, active-high
//   tx_data   in   DATA_W  byte to send; captured on handshake
//   tx_valid  in   1       request to start a transfer
//   tx_ready  out  1       block can accept tx_data this cycle
//   rx_data   out  DATA_W  byte shifted in from miso; held until next rx_valid
//   rx_valid  out  1       one-cycle pulse: rx_data updated, transfer done
//   busy      out  1       high from accept until return to IDLE
//   sclk      out  1       SPI clock, idle low
//   cs        out  1       chip select, active low
//   mosi      out  1       master out
//   miso      in   1       master in (sampled in clk domain)
// BEHAVIOUR
// - All outputs registered. rst high: sclk=0, cs=1, mosi=0, tx_ready=0, rx_valid=0,
//   busy=0, rx_data=0, state=IDLE, counters=0. Reset mid-transfer aborts immediately
//   (cs=1 on next edge); no rx_valid for the aborted byte. tx_ready=1 first cycle after rst low.
// - Handshake: transfer accepted on the cycle tx_valid && tx_ready (cycle 0). tx_ready=1 only
//   in IDLE (plus burst slot below). tx_data latched into shift reg; later changes ignored.
// - States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   SETUP: cycle 1 cs=0, mosi=tx_data[DATA_W-1], busy=1; lasts CLK_DIV cycles.
//   SHIFT: sclk toggles every CLK_DIV cycles; first rise at cycle 1+CLK_DIV.
//     rising edge cycle: miso shifted into rx shift reg LSB (MSB first).
//     falling edge cycle: mosi <= next bit. After DATA_W rises, final fall at
//     cycle 1+2*DATA_W*CLK_DIV; mosi unchanged there -> HOLD.
//   HOLD: CLK_DIV cycles, sclk=0, cs=0; then cs=1, rx_data updated, rx_valid=1 same cycle.
//   GAP: cs=1 for CS_GAP cycles, mosi=0; then IDLE, busy=0, tx_ready=1.
// - Latency: accept -> rx_valid = 1+(2*DATA_W+1)*CLK_DIV cycles (DATA_W=8,CLK_DIV=2: 35).
// - Half-period counter width $clog2(CLK_DIV); counts 0..CLK_DIV-1, wraps; bit counter
//   $clog2(DATA_W+1) bits. No counter exceeds its range; no miso synchroniser (sclk is ours).
// - tx_valid while busy (non-burst): ignored, tx_ready=0; request stays pending for IDLE.
// CONFIGURATION
//   SPI_BURST_EN defined: tx_ready also =1 in the final-fall cycle of SHIFT. If tx_valid
//     then: new byte latched, cs stays 0, mosi=new MSB that cycle, HOLD/GAP skipped, next rise
//     CLK_DIV later; rx_valid for previous byte pulses that same cycle. No tx_valid: normal HOLD.
//   Not defined: cs always deasserts after each byte; burst slot absent; tx_ready IDLE-only.
// TESTING (CLK_DIV=2, DATA_W=8, CS_GAP=4)
//   1 send 0xA5, miso tied to echo pattern 0x3C -> mosi bits 1,0,1,0,0,1,0,1 valid at each
//     rise; rx_data=0x3C, rx_valid one pulse at cycle 35; cs low cycles 1..34.
//   2 reset asserted mid-SHIFT (bit 4) -> cs=1, sclk=0, mosi=0 next edge; no rx_valid;
//     next 0x81 transfer correct.
//   3 tx_valid held high, data 0x01 then 0x02, no burst -> two frames, cs high exactly
//     CS_GAP cycles between, tx_ready low throughout each frame.
//   4 SPI_BURST_EN, back-to-back 0xFF,0x00 -> cs low continuously, 16 rises, rx_valid
//     pulses at end of each byte, rising edges evenly spaced 2*CLK_DIV.
//   5 tx_data changed after accept (0x55 -> 0xAA) -> mosi shifts 0x55; sclk count per
//     frame = 8, sclk idle low, never high with cs=1.

Source files
------------

// File: rtl/spi_master_tx_if.sv
// rtl/spi_master_tx_if.sv - transfer request/response bundle for spi_master_tx
interface spi_master_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;

   // master: the client that requests transfers; slave: the SPI master block itself
   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, busy
   );
   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - SPI mode-0 master, MSB first; SPI_BURST_EN enables back-to-back bytes under one cs
module spi_master_tx #(
   parameter int CLK_DIV = 25,
   parameter int DATA_W  = 8,
   parameter int CS_GAP  = 4
) (
   input  logic           clk,
   input  logic           rst,
   spi_master_tx_if.slave bus,
   output logic           sclk,
   output logic           cs,
   output logic           mosi,
   input  logic           miso
);
   localparam int HW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP - 1) : 1;

   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W);
   // The IDLE cycle that re-accepts a request counts as the last cs-high cycle,
   // so GAP itself lasts CS_GAP-1 cycles.
   localparam logic [GW-1:0] GAP_LAST  = GW'((CS_GAP >= 2) ? CS_GAP - 2 : 0);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state;
   logic [HW-1:0]     half_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_data_q;
   logic              tx_ready_q;
   logic              rx_valid_q;
   logic              busy_q;
   logic              sclk_q;
   logic              cs_q;
   logic              mosi_q;
   logic              half_done;

   assign half_done    = (half_cnt == HALF_LAST);
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_q;
   assign sclk         = sclk_q;
   assign cs           = cs_q;
   assign mosi         = mosi_q;

   // Transfer sequencer: generates sclk from half-period counts and shifts both directions
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         half_cnt   <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         rx_data_q  <= '0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               tx_ready_q <= 1'b1;
               if (bus.tx_valid && tx_ready_q) begin
                  tx_shift   <= bus.tx_data;
                  mosi_q     <= bus.tx_data[DATA_W-1];
                  cs_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  tx_ready_q <= 1'b0;
                  half_cnt   <= '0;
                  bit_cnt    <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               half_cnt <= half_cnt + 1'b1;
               if (half_done) begin
                  half_cnt <= '0;
                  sclk_q   <= 1'b1;
                  rx_shift <= {rx_shift[DATA_W-2:0], miso};
                  bit_cnt  <= bit_cnt + 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               half_cnt <= half_cnt + 1'b1;
               if (half_done) begin
                  half_cnt <= '0;
                  if (!sclk_q) begin
                     sclk_q   <= 1'b1;
                     rx_shift <= {rx_shift[DATA_W-2:0], miso};
                     bit_cnt  <= bit_cnt + 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= HOLD;
`ifdef SPI_BURST_EN
                        tx_ready_q <= 1'b1;
`endif
                     end else begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        mosi_q   <= tx_shift[DATA_W-2];
                     end
                  end
               end
            end
            HOLD: begin
               half_cnt   <= half_cnt + 1'b1;
               tx_ready_q <= 1'b0;
`ifdef SPI_BURST_EN
               // Burst slot: the half-period count keeps running so rises stay evenly spaced
               if (tx_ready_q && bus.tx_valid) begin
                  tx_shift   <= bus.tx_data;
                  mosi_q     <= bus.tx_data[DATA_W-1];
                  rx_data_q  <= rx_shift;
                  rx_valid_q <= 1'b1;
                  bit_cnt    <= '0;
                  state      <= SHIFT;
               end else
`endif
               if (half_done) begin
                  half_cnt   <= '0;
                  cs_q       <= 1'b1;
                  mosi_q     <= 1'b0;
                  rx_data_q  <= rx_shift;
                  rx_valid_q <= 1'b1;
                  gap_cnt    <= '0;
                  if (CS_GAP == 1) begin
                     state      <= IDLE;
                     busy_q     <= 1'b0;
                     tx_ready_q <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt    <= '0;
                  state      <= IDLE;
                  busy_q     <= 1'b0;
                  tx_ready_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - randomized self-checking bench for spi_master_tx (SPI_BURST_EN selects burst scenario)
`timescale 1ns/1ps
module tb_spi_master_tx;
   localparam int CLK_DIV = 2;
   localparam int DATA_W  = 8;
   localparam int CS_GAP  = 4;
   localparam int LAT     = 1 + (2 * DATA_W + 1) * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk, cs, mosi;
   logic miso = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   spi_master_tx_if #(.DATA_W(DATA_W)) bus ();

   spi_master_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CS_GAP(CS_GAP)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi),
      .miso (miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation and slave model state
   logic [7:0] slave_byte = 8'h00;
   int         frame_rises = 0;
   bit         prev_sclk = 1'b0;
   bit         prev_cs = 1'b1;
   bit         rise_bits[$];
   int         rise_cyc[$];
   int         rxv_cyc[$];
   logic [7:0] rxv_data[$];
   int         cs_fall_cyc[$];
   int         cs_rise_cyc[$];
   int         sclk_cs_bad = 0;
   int         ready_cs_low = 0;

   // Mode-0 slave: presents the next MSB-first bit of slave_byte after every observed rise
   always @(negedge clk) begin
      int idx;
      if (sclk === 1'b1 && !prev_sclk) begin
         rise_bits.push_back(mosi);
         rise_cyc.push_back(cyc);
         frame_rises = frame_rises + 1;
      end
      if (sclk === 1'b1 && cs === 1'b1) sclk_cs_bad++;
      if (cs === 1'b0 && bus.tx_ready === 1'b1) ready_cs_low++;
      if (cs === 1'b0 && prev_cs) cs_fall_cyc.push_back(cyc);
      if (cs === 1'b1 && !prev_cs) cs_rise_cyc.push_back(cyc);
      if (cs === 1'b1) frame_rises = 0;
      if (bus.rx_valid === 1'b1) begin
         rxv_cyc.push_back(cyc);
         rxv_data.push_back(bus.rx_data);
      end
      idx = 7 - (frame_rises % 8);
      miso = slave_byte[idx];
      prev_sclk = (sclk === 1'b1);
      prev_cs = (cs !== 1'b0);
   end

   task automatic clear_mon();
      rise_bits.delete();
      rise_cyc.delete();
      rxv_cyc.delete();
      rxv_data.delete();
      cs_fall_cyc.delete();
      cs_rise_cyc.delete();
      sclk_cs_bad = 0;
      ready_cs_low = 0;
   endtask

   task automatic wait_accept(output int acc);
      int n = 0;
      while (bus.tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: tx_ready=%b required 1", bus.tx_ready);
      end
      acc = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(bus.busy === 1'b0 && bus.tx_ready === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b required 0", bus.busy);
      end
   endtask

   // One isolated transfer; tx_data is scrambled right after the handshake
   task automatic send_one(input logic [7:0] d, input logic [7:0] sb, output int acc);
      clear_mon();
      slave_byte = sb;
      @(negedge clk);
      bus.tx_data = d;
      bus.tx_valid = 1'b1;
      wait_accept(acc);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data = ~d;
      wait_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", sclk); end
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", cs); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", mosi); end
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b want 0", bus.tx_ready); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", bus.rx_data); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.tx_ready); end
   endtask

   task automatic test_single_frames();
      int         acc;
      int         terr;
      logic [7:0] d, sb, got;
      for (int f = 0; f < 6; f++) begin
         d  = (f == 0) ? 8'hA5 : 8'($urandom);
         sb = (f == 0) ? 8'h3C : 8'($urandom);
         send_one(d, sb, acc);
         got = 8'h00;
         terr = 0;
         for (int i = 0; i < rise_bits.size() && i < DATA_W; i++) begin
            got[DATA_W-1-i] = rise_bits[i];
            if (rise_cyc[i] != acc + 1 + (2 * i + 1) * CLK_DIV) terr++;
         end
         checks++; if (rise_bits.size() != DATA_W) begin errors++; $display("FAIL single_rises: got %0d want %0d", rise_bits.size(), DATA_W); end
         checks++; if (got !== d) begin errors++; $display("FAIL single_mosi: got %h want %h", got, d); end
         checks++; if (terr != 0) begin errors++; $display("FAIL single_rise_timing: %0d misplaced rises want 0", terr); end
         checks++; if (rxv_cyc.size() != 1) begin errors++; $display("FAIL single_rxv_count: got %0d want 1", rxv_cyc.size()); end
         if (rxv_cyc.size() >= 1) begin
            checks++; if (rxv_data[0] !== sb) begin errors++; $display("FAIL single_rx_data: got %h want %h", rxv_data[0], sb); end
            checks++; if (rxv_cyc[0] - acc != LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", rxv_cyc[0] - acc, LAT); end
         end
         checks++; if (cs_fall_cyc.size() != 1 || cs_fall_cyc[0] != acc + 1) begin errors++; $display("FAIL single_cs_fall: falls %0d want 1 at offset 1", cs_fall_cyc.size()); end
         checks++; if (cs_rise_cyc.size() != 1 || cs_rise_cyc[0] != acc + LAT) begin errors++; $display("FAIL single_cs_rise: rises %0d want 1 at offset %0d", cs_rise_cyc.size(), LAT); end
         checks++; if (sclk_cs_bad != 0) begin errors++; $display("FAIL single_sclk_cs: got %0d cycles want 0", sclk_cs_bad); end
`ifndef SPI_BURST_EN
         checks++; if (ready_cs_low != 0) begin errors++; $display("FAIL single_ready_in_frame: got %0d cycles want 0", ready_cs_low); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      int         acc, n;
      logic [7:0] sb, got;
      clear_mon();
      slave_byte = 8'($urandom);
      @(negedge clk);
      bus.tx_data = 8'h5A;
      bus.tx_valid = 1'b1;
      wait_accept(acc);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      n = 0;
      while (rise_cyc.size() < 5 && n < 100) begin @(negedge clk); n++; end
      checks++; if (rise_cyc.size() < 5) begin errors++; $display("FAIL abort_reach_bit4: rises %0d want 5", rise_cyc.size()); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cs !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL abort_pins: cs=%b sclk=%b mosi=%b want 1 0 0", cs, sclk, mosi); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      checks++; if (rxv_cyc.size() != 0) begin errors++; $display("FAIL abort_rx_valid: got %0d pulses want 0", rxv_cyc.size()); end
      sb = 8'($urandom);
      send_one(8'h81, sb, acc);
      got = 8'h00;
      for (int i = 0; i < rise_bits.size() && i < DATA_W; i++) got[DATA_W-1-i] = rise_bits[i];
      checks++; if (got !== 8'h81) begin errors++; $display("FAIL after_abort_mosi: got %h want 81", got); end
      checks++; if (rxv_data.size() != 1 || rxv_data[0] !== sb) begin errors++; $display("FAIL after_abort_rx: pulses %0d want 1 with %h", rxv_data.size(), sb); end
      checks++; if (rxv_cyc.size() != 1 || rxv_cyc[0] - acc != LAT) begin errors++; $display("FAIL after_abort_latency: pulses %0d want 1 at %0d", rxv_cyc.size(), LAT); end
   endtask

   task automatic test_data_change();
      int         acc;
      logic [7:0] got;
      send_one(8'h55, 8'($urandom), acc);
      got = 8'h00;
      for (int i = 0; i < rise_bits.size() && i < DATA_W; i++) got[DATA_W-1-i] = rise_bits[i];
      checks++; if (got !== 8'h55) begin errors++; $display("FAIL change_mosi: got %h want 55", got); end
      checks++; if (rise_bits.size() != DATA_W) begin errors++; $display("FAIL change_rises: got %0d want %0d", rise_bits.size(), DATA_W); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL change_sclk_idle: got %b want 0", sclk); end
      checks++; if (sclk_cs_bad != 0) begin errors++; $display("FAIL change_sclk_cs: got %0d want 0", sclk_cs_bad); end
   endtask

`ifdef SPI_BURST_EN
   task automatic test_burst();
      int         a0, a1, serr;
      logic [7:0] sb, g0, g1;
      clear_mon();
      sb = 8'($urandom);
      slave_byte = sb;
      @(negedge clk);
      bus.tx_data = 8'hFF;
      bus.tx_valid = 1'b1;
      wait_accept(a0);
      @(negedge clk);
      bus.tx_data = 8'h00;
      wait_accept(a1);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      wait_idle();
      g0 = 8'h00; g1 = 8'h00; serr = 0;
      for (int i = 0; i < rise_bits.size() && i < 2 * DATA_W; i++) begin
         if (i < DATA_W) g0[DATA_W-1-i] = rise_bits[i];
         else            g1[2*DATA_W-1-i] = rise_bits[i];
         if (i > 0 && rise_cyc[i] - rise_cyc[i-1] != 2 * CLK_DIV) serr++;
      end
      checks++; if (a1 - a0 != 1 + 2 * DATA_W * CLK_DIV) begin errors++; $display("FAIL burst_slot: got %0d want %0d", a1 - a0, 1 + 2 * DATA_W * CLK_DIV); end
      checks++; if (rise_bits.size() != 2 * DATA_W) begin errors++; $display("FAIL burst_rises: got %0d want %0d", rise_bits.size(), 2 * DATA_W); end
      checks++; if (serr != 0) begin errors++; $display("FAIL burst_spacing: %0d uneven gaps want 0", serr); end
      checks++; if (cs_fall_cyc.size() != 1 || cs_rise_cyc.size() != 1) begin errors++; $display("FAIL burst_cs: falls %0d rises %0d want 1 1", cs_fall_cyc.size(), cs_rise_cyc.size()); end
      checks++; if (g0 !== 8'hFF || g1 !== 8'h00) begin errors++; $display("FAIL burst_mosi: got %h %h want ff 00", g0, g1); end
      checks++; if (rxv_cyc.size() != 2) begin errors++; $display("FAIL burst_rxv_count: got %0d want 2", rxv_cyc.size()); end
      if (rxv_cyc.size() == 2 && rise_cyc.size() == 2 * DATA_W) begin
         checks++; if (rxv_data[0] !== sb || rxv_data[1] !== sb) begin errors++; $display("FAIL burst_rx_data: got %h %h want %h", rxv_data[0], rxv_data[1], sb); end
         checks++; if (rxv_cyc[0] <= rise_cyc[DATA_W-1] || rxv_cyc[0] >= rise_cyc[DATA_W]) begin errors++; $display("FAIL burst_rxv0_place: got %0d want between %0d and %0d", rxv_cyc[0], rise_cyc[DATA_W-1], rise_cyc[DATA_W]); end
         checks++; if (rxv_cyc[1] - a0 != LAT + 2 * DATA_W * CLK_DIV) begin errors++; $display("FAIL burst_rxv1_time: got %0d want %0d", rxv_cyc[1] - a0, LAT + 2 * DATA_W * CLK_DIV); end
      end
   endtask
`else
   task automatic test_back_to_back();
      int         a0, a1, rerr;
      logic [7:0] sb, g0, g1;
      clear_mon();
      sb = 8'($urandom);
      slave_byte = sb;
      @(negedge clk);
      bus.tx_data = 8'h01;
      bus.tx_valid = 1'b1;
      wait_accept(a0);
      @(negedge clk);
      bus.tx_data = 8'h02;
      wait_accept(a1);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      wait_idle();
      g0 = 8'h00; g1 = 8'h00; rerr = 0;
      for (int i = 0; i < rise_bits.size() && i < 2 * DATA_W; i++) begin
         if (i < DATA_W) g0[DATA_W-1-i] = rise_bits[i];
         else            g1[2*DATA_W-1-i] = rise_bits[i];
      end
      checks++; if (a1 - a0 != LAT + CS_GAP - 1) begin errors++; $display("FAIL b2b_second_accept: got %0d want %0d", a1 - a0, LAT + CS_GAP - 1); end
      checks++; if (cs_fall_cyc.size() != 2 || cs_rise_cyc.size() != 2) begin errors++; $display("FAIL b2b_frames: falls %0d rises %0d want 2 2", cs_fall_cyc.size(), cs_rise_cyc.size()); end
      else begin
         checks++; if (cs_fall_cyc[1] - cs_rise_cyc[0] != CS_GAP) begin errors++; $display("FAIL b2b_cs_gap: got %0d want %0d", cs_fall_cyc[1] - cs_rise_cyc[0], CS_GAP); end
      end
      checks++; if (ready_cs_low != 0) begin errors++; $display("FAIL b2b_ready_in_frame: got %0d want 0", ready_cs_low); end
      checks++; if (g0 !== 8'h01 || g1 !== 8'h02) begin errors++; $display("FAIL b2b_mosi: got %h %h want 01 02", g0, g1); end
      checks++; if (rxv_data.size() != 2) begin errors++; $display("FAIL b2b_rxv_count: got %0d want 2", rxv_data.size()); end
      else begin
         rerr = (rxv_data[0] !== sb) + (rxv_data[1] !== sb);
         checks++; if (rerr != 0) begin errors++; $display("FAIL b2b_rx_data: got %h %h want %h", rxv_data[0], rxv_data[1], sb); end
      end
   endtask
`endif

   initial begin
      bus.tx_data = 8'h00;
      bus.tx_valid = 1'b0;
      test_reset();
      test_single_frames();
      test_reset_mid();
      test_data_change();
`ifdef SPI_BURST_EN
      test_burst();
`else
      test_back_to_back();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1);
   end
endmodule
